// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the divider.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_div;
    logic [WIDTH-1:0]     opdata1;
    logic [WIDTH-1:0]     opdata2;
    logic                 annul;
    logic                 busy;
    logic                 ready;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  busy, ready, result
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output busy, ready, result
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// result = {remainder, quotient}; busy stalls the pipeline while iterating.
module div_unit #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [2*WIDTH:0]     sr;
    logic [WIDTH-1:0]     divisor;
    logic                 sgn;
    logic                 neg_dd;
    logic                 neg_dv;
    logic [CW-1:0]        counter;
    logic [2*WIDTH-1:0]   result_q;

    logic                 accept;
    logic                 last_step;
    logic [WIDTH-1:0]     abs1;
    logic [WIDTH-1:0]     abs2;
    logic [2*WIDTH+1:0]   shifted;
    logic [WIDTH+1:0]     trial;
    logic [2*WIDTH:0]     step_sr;
    logic [WIDTH-1:0]     quo_raw;
    logic [WIDTH-1:0]     rem_raw;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign accept    = (state == S_IDLE) && bus.start && !bus.annul;
    assign last_step = (counter == CW'(WIDTH - 1));

    // Operand magnitudes and one restoring step with sign correction of its outcome.
    always_comb begin
        abs1 = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
        abs2 = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;

        // Upper slice carries the shifted-out MSB so the trial subtract sees the full partial remainder.
        shifted = {sr, 1'b0};
        trial   = shifted[2*WIDTH+1:WIDTH] - {2'b00, divisor};
        if (!trial[WIDTH+1]) begin
            step_sr = {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
        end else begin
            step_sr = shifted[2*WIDTH:0];
        end

        quo_raw = step_sr[WIDTH-1:0];
        rem_raw = step_sr[2*WIDTH-1:WIDTH];
        quo_fix = (sgn && (neg_dd ^ neg_dv)) ? -quo_raw : quo_raw;
        rem_fix = (sgn && neg_dd) ? -rem_raw : rem_raw;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (bus.opdata2 == '0) ? S_DIVZERO : S_ON;
                end
            end
            S_DIVZERO: begin
                state_nxt = bus.annul ? S_IDLE : S_END;
            end
            S_ON: begin
                if (bus.annul) begin
                    state_nxt = S_IDLE;
                end else if (last_step) begin
                    state_nxt = S_END;
                end
            end
            S_END: begin
                if (!bus.start) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration and result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            divisor  <= '0;
            sgn      <= 1'b0;
            neg_dd   <= 1'b0;
            neg_dv   <= 1'b0;
            counter  <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && (bus.opdata2 != '0)) begin
                        sr      <= {{(WIDTH + 1){1'b0}}, abs1};
                        divisor <= abs2;
                        sgn     <= bus.signed_div;
                        neg_dd  <= bus.opdata1[WIDTH-1];
                        neg_dv  <= bus.opdata2[WIDTH-1];
                        counter <= '0;
                    end
                end
                S_DIVZERO: begin
                    if (!bus.annul) begin
                        result_q <= '0;
                    end
                end
                S_ON: begin
                    if (!bus.annul) begin
                        sr      <= step_sr;
                        counter <= counter + 1'b1;
                        if (last_step) begin
                            result_q <= {rem_fix, quo_fix};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs decoded from state.
    always_comb begin
        bus.busy   = (state == S_DIVZERO) || (state == S_ON);
        bus.ready  = (state == S_END);
        bus.result = result_q;
    end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [63:0] last_res = '0;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero; x/0 gives 0.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // mode 0: hold inputs; 1: scramble operands while running; 2: scramble and drop start mid-run
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                           input int mode, input string tag);
        logic [63:0] exp;
        int cycles;
        bit done;
        exp    = ref_div(a, b, s);
        cycles = 0;
        done   = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.opdata1 = a; bus.opdata2 = b; bus.signed_div = s; bus.annul = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                done = 1'b1;
            end else begin
                if (bus.busy) cycles++;
                if (mode != 0) begin
                    bus.opdata1 = $urandom; bus.opdata2 = $urandom; bus.signed_div = 1'($urandom);
                end
                if (mode == 2 && cycles == 5) bus.start = 1'b0;
            end
        end
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " busy_cycles"}, 64'(cycles), (b == 32'd0) ? 64'd1 : 64'd32);
        check({tag, " result"}, bus.result, exp);
        check({tag, " busy_at_ready"}, 64'(bus.busy), 64'd0);
        last_res = exp;
        if (mode == 2) begin
            @(negedge clk);
            check({tag, " ready_drop"}, 64'(bus.ready), 64'd0);
            check({tag, " result_kept"}, bus.result, exp);
        end else begin
            @(negedge clk);
            check({tag, " ready_hold"}, 64'(bus.ready), 64'd1);
            check({tag, " result_hold"}, bus.result, exp);
            bus.start = 1'b0;
            @(negedge clk);
            check({tag, " ready_drop"}, 64'(bus.ready), 64'd0);
            check({tag, " result_kept"}, bus.result, exp);
        end
    endtask

    // Start a divide and wait n busy cycles, leaving the caller at a negedge mid-run.
    task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input int n);
        @(negedge clk);
        bus.start = 1'b1; bus.opdata1 = a; bus.opdata2 = b; bus.signed_div = 1'b0; bus.annul = 1'b0;
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit rs;
        int rm;
        bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
        bus.opdata1 = '0; bus.opdata2 = '0;

        repeat (2) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset ready", 64'(bus.ready), 64'd0);
        check("reset result", bus.result, 64'd0);
        rst = 1'b0;

        run_div(32'd100, 32'd7, 1'b0, 0, "divu_100_7");
        check("divu_100_7 const", last_res, 64'h00000002_0000000E);
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, 0, "div_m7_2");
        run_div(32'd7, 32'hFFFFFFFE, 1'b1, 0, "div_7_m2");
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, "div_min_m1");
        run_div(32'hFFFFFFFF, 32'h10, 1'b0, 0, "divu_max_16");
        run_div(32'd1234, 32'd0, 1'b1, 0, "div_zero_s");
        run_div(32'hDEADBEEF, 32'd0, 1'b0, 0, "div_zero_u");

        // annul mid-run: aborts, result untouched, no ready
        start_and_wait(32'd100, 32'd7, 10);
        bus.annul = 1'b1;
        @(negedge clk);
        check("annul busy", 64'(bus.busy), 64'd0);
        check("annul ready", 64'(bus.ready), 64'd0);
        check("annul result", bus.result, last_res);
        // start with annul held is ignored
        bus.start = 1'b1;
        @(negedge clk);
        check("annul_start busy", 64'(bus.busy), 64'd0);
        bus.start = 1'b0; bus.annul = 1'b0;
        repeat (3) @(negedge clk);
        check("annul ready_stays_low", 64'(bus.ready), 64'd0);
        run_div(32'd9, 32'd3, 1'b0, 0, "after_annul_9_3");

        // annul on the divide-by-zero path
        @(negedge clk);
        bus.start = 1'b1; bus.opdata1 = 32'd5; bus.opdata2 = 32'd0; bus.annul = 1'b0;
        @(negedge clk);
        check("dz_annul busy", 64'(bus.busy), 64'd1);
        bus.annul = 1'b1; bus.start = 1'b0;
        @(negedge clk);
        check("dz_annul ready", 64'(bus.ready), 64'd0);
        check("dz_annul result", bus.result, last_res);
        bus.annul = 1'b0;

        // synchronous reset mid-run
        start_and_wait(32'd1000, 32'd3, 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst ready", 64'(bus.ready), 64'd0);
        check("rst result", bus.result, 64'd0);

        // operands and start disturbed after acceptance
        run_div(32'd123456789, 32'd1000, 1'b0, 1, "scramble_u");
        run_div(32'h87654321, 32'd77, 1'b1, 2, "scramble_drop_s");

        for (int k = 0; k < 16; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 300);
                2: rb = -32'($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom);
            rm = (rb == 32'd0) ? 0 : int'($urandom_range(0, 2));
            run_div(ra, rb, rs, rm, $sformatf("rand%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the EX stage, alongside the single-cycle ALU.
- Its 64-bit {remainder, quotient} output feeds the same HI/LO write path as the ALU's multiply result: HI receives the remainder, LO receives the quotient.
- Asserts busy so the hazard unit can stall the pipeline while the divide iterates.
- Handles signed and unsigned operands, divide-by-zero, and abort when the EX instruction is flushed.

Parameters:
- WIDTH, 32, operand width. Result is 2*WIDTH. Only 32 is required to be supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a divide; sampled only in IDLE
- signed_div  input  1  1 = DIV (signed), 0 = DIVU (unsigned); latched with the operands
- opdata1  input  WIDTH  dividend (rs)
- opdata2  input  WIDTH  divisor (rt)
- annul  input  1  abort the in-flight divide (EX flush or exception)
- busy  output  1  divide in progress; stall request
- ready  output  1  result valid
- result  output  2*WIDTH  {remainder[63:32], quotient[31:0]}

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high and dominates all other inputs. Reset values: state=IDLE, busy=0, ready=0, result=0, counter=0.
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - start=1 and annul=0 and opdata2==0 -> DIVZERO.
  - start=1 and annul=0 and opdata2!=0 -> ON. On that edge latch: |opdata1| into the dividend register, |opdata2| into the divisor register, signed_div, sign(opdata1), sign(opdata2); clear the counter.
  - Absolute values are taken only when signed_div=1; otherwise operands are used raw.
  - start=1 with annul=1 is ignored. ready=0 in IDLE.
- DIVZERO: next edge -> END with result=0 and ready=1.
- ON:
  - Each edge performs one restoring step on a 2*WIDTH+1 shift register: shift left one bit, trial-subtract the divisor from the upper half. If no borrow, keep the difference and set quotient bit=1; else restore and set quotient bit=0.
  - The counter increments on each step.
  - Step 32 (counter==31) -> END on the same edge, with result loaded and ready=1.
- Sign correction (signed_div=1), applied when loading result:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0. No trap is raised.
- END:
  - ready=1 and result is held stable while start=1.
  - start=0 -> IDLE; ready drops to 0 on that edge. result keeps its value until the next load.
- busy = 1 in DIVZERO and ON, 0 in IDLE and END.
- Latency: with start accepted at edge E0, ready is first visible after edge E32 (32 cycles in ON). The divide-by-zero path gives ready after E1.
- annul=1 in DIVZERO or ON -> IDLE on the next edge. ready is never asserted and result is unchanged. annul is ignored in END.
- Changes to opdata1, opdata2, signed_div or start after acceptance have no effect; start dropping mid-ON does not abort the divide.
- rst asserted in any state returns to IDLE next edge with all outputs at their reset values.

Test Plan:
- DIVU: opdata1=100, opdata2=7 -> busy for 32 cycles; then ready=1 and result=0x00000002_0000000E, held until start drops.
- DIV: opdata1=0xFFFFFFF9 (-7), opdata2=2 -> result=0xFFFFFFFF_FFFFFFFD (rem -1, quo -3). Also 7/-2 -> 0x00000001_FFFFFFFD.
- DIV: 0x80000000 / 0xFFFFFFFF -> result=0x00000000_80000000. DIVU: 0xFFFFFFFF / 0x10 -> 0x0000000F_0FFFFFFF.
- Divide by zero: opdata2=0 (signed and unsigned) -> ready=1 one cycle after acceptance, result=0, busy=1 for exactly one cycle.
- annul at cycle 10 of ON -> busy=0 next cycle, ready never rises. A following start with 9/3 completes correctly with result=0x00000000_00000003.
- rst pulsed at cycle 20 of ON -> busy=0, ready=0, result=0 next cycle. Operands changed mid-operation (no reset) do not alter the result.
